mbist_march: RTL

MBIST_MARCH -- requirements
Module: mbist_march

---
 rtl/mbist_march.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mbist_march.sv
// March C- memory BIST engine wrapped around a single-port RAM with a normal-mode
// access path and a stuck-at fault injector on the read data.
module mbist_march #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        opr,
    input  logic                        csin,
    input  logic                        rwbarin,
    input  logic [ADDR_W-1:0]           address,
    input  logic [DATA_W-1:0]           datain,
    input  logic                        bg_sel,
    input  logic                        fi_en,
    input  logic [ADDR_W-1:0]           fi_addr,
    input  logic [$clog2(DATA_W)-1:0]   fi_bit,
    input  logic                        fi_val,
    output logic [DATA_W-1:0]           dataout,
    output logic                        busy,
    output logic                        done,
    output logic                        fail,
    output logic [ADDR_W-1:0]           fail_addr,
    output logic [DATA_W-1:0]           fail_exp,
    output logic [CNT_W-1:0]            fail_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] CHECKER = {DATA_W/2{2'b01}};

    typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, M4, M5, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                phase_q, phase_d;
    logic                fail_q, fail_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0]   fail_exp_q, fail_exp_d;
    logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                running, two_op, down, rd_op, wr_op, mismatch;
    logic [DATA_W-1:0]   bg_word, exp_word, wr_word, eng_rd;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    // Stuck-at model applies to the read path only; stored contents stay intact.
    function automatic logic [DATA_W-1:0] inject(
        input logic [DATA_W-1:0]         word,
        input logic [ADDR_W-1:0]         addr,
        input logic                      en,
        input logic [ADDR_W-1:0]         f_addr,
        input logic [$clog2(DATA_W)-1:0] f_bit,
        input logic                      f_val
    );
        logic [DATA_W-1:0] w;
        w = word;
        if (en && addr == f_addr) w[f_bit] = f_val;
        return w;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no latch can be inferred.
        running  = (state_q inside {M0, M1, M2, M3, M4, M5});
        two_op   = (state_q inside {M1, M2, M3, M4});
        down     = (state_q inside {M3, M4});
        rd_op    = two_op ? !phase_q : (state_q == M5);
        wr_op    = two_op ?  phase_q : (state_q == M0);
        bg_word  = bg_sel ? (addr_q[0] ? ~CHECKER : CHECKER) : '0;
        exp_word = (state_q inside {M2, M4}) ? ~bg_word : bg_word;
        wr_word  = (state_q inside {M1, M3}) ? ~bg_word : bg_word;
        eng_rd   = inject(mem[addr_q], addr_q, fi_en, fi_addr, fi_bit, fi_val);
        mismatch = running && opr && rd_op && (eng_rd != exp_word);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_cnt_d  = fail_cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start && opr) begin
                    state_d     = M0;
                    addr_d      = '0;
                    phase_d     = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_cnt_d  = '0;
                end else if (state_q == DONE && !opr) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (!opr) begin
                    // Abort keeps whatever results were gathered so far.
                    state_d = IDLE;
                end else begin
                    if (mismatch) begin
                        fail_d = 1'b1;
                        if (!fail_q) begin
                            fail_addr_d = addr_q;
                            fail_exp_d  = exp_word;
                        end
                        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
                    end
                    if (two_op && !phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (addr_q == (down ? '0 : '1)) begin
                            // Element boundary: next element starts at its own sweep origin.
                            case (state_q)
                                M0:      begin state_d = M1;   addr_d = '0; end
                                M1:      begin state_d = M2;   addr_d = '0; end
                                M2:      begin state_d = M3;   addr_d = '1; end
                                M3:      begin state_d = M4;   addr_d = '1; end
                                M4:      begin state_d = M5;   addr_d = '0; end
                                default: begin state_d = DONE; addr_d = '0; end
                            endcase
                        end else begin
                            addr_d = down ? addr_q - 1'b1 : addr_q + 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = address;
        mem_wdata = datain;
        if (running) begin
            mem_we    = opr && wr_op;
            mem_waddr = addr_q;
            mem_wdata = wr_word;
        end else if (!opr && csin && !rwbarin) begin
            mem_we = 1'b1;
        end
    end

    always_comb begin
        dataout = '0;
        if (!opr && csin && rwbarin)
            dataout = inject(mem[address], address, fi_en, fi_addr, fi_bit, fi_val);
    end

    // NOTE: the RAM array has no reset; its contents survive rst by design.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign busy      = running;
    assign done      = (state_q == DONE);
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_exp  = fail_exp_q;
    assign fail_cnt  = fail_cnt_q;

endmodule
